// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial-bus arbiter and its round-robin picker.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_XFER,
        ARB_GAP
    } arb_state_t;

    localparam int FRAME_BITS = 8;
    localparam int GRANT_ID_W = 3;
    // Watchdog counts to twice a frame length before it saturates.
    localparam int WDOG_W     = $clog2(2 * FRAME_BITS);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches the request vector starting one past
// rr_ptr, wrapping modulo NUM_SLAVES, and reports the first requester found.
module rr_priority_picker
    import serial_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 3
) (
    input  logic [NUM_SLAVES-1:0] req,
    input  logic [GRANT_ID_W-1:0] rr_ptr,
    output logic [GRANT_ID_W-1:0] winner,
    output logic                  any_req
);

    localparam int SW = GRANT_ID_W + 1;

    logic [GRANT_ID_W-1:0] cand [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] hit;

    // cand[gi] is the slave at rotation offset gi+1; rr_ptr < NUM_SLAVES so one
    // conditional subtraction is enough to wrap.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum      = {1'b0, rr_ptr} + SW'(gi + 1);
            assign cand[gi] = (sum >= SW'(NUM_SLAVES)) ? GRANT_ID_W'(sum - SW'(NUM_SLAVES))
                                                       : sum[GRANT_ID_W-1:0];
            assign hit[gi]  = |(req & (NUM_SLAVES'(1) << cand[gi]));
        end
    endgenerate

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner  = cand[i];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter steering one granted slave's 8-bit LSB-first serial frame onto
// a registered bus output, with a saturating watchdog for frames that never complete.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int TIMEOUT    = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_rx_ready,
    input  logic [NUM_SLAVES-1:0] s_valid,
    input  logic [NUM_SLAVES-1:0] s_tx_done,
    input  logic [NUM_SLAVES-1:0] tx_data,
    output logic [NUM_SLAVES-1:0] m_ready,
    output logic                  bus_data,
    output logic                  bus_valid,
    output logic                  bus_last,
    output logic [GRANT_ID_W-1:0] grant_id,
    output logic                  frame_done,
    output logic                  timeout_err
);

    localparam int WI = WDOG_W + 1;

    arb_state_t            state_q, state_d;
    logic [GRANT_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GRANT_ID_W-1:0] grant_q, grant_d;
    logic [NUM_SLAVES-1:0] m_ready_q, m_ready_d;
    logic                  bus_data_q, bus_data_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_last_q, bus_last_d;
    logic                  frame_done_q, frame_done_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;

    logic [GRANT_ID_W-1:0] winner;
    logic                  any_req;
    logic [NUM_SLAVES-1:0] grant_mask;
    logic                  sel_valid;
    logic                  sel_done;
    logic                  sel_data;
    logic [WI-1:0]         wdog_inc;

    rr_priority_picker #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_picker (
        .req     (s_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Only the granted slave's lines are ever looked at.
    assign grant_mask = NUM_SLAVES'(1) << grant_q;
    assign sel_valid  = |(s_valid & grant_mask);
    assign sel_done   = |(s_tx_done & grant_mask);
    assign sel_data   = |(tx_data & grant_mask);
    assign wdog_inc   = {1'b0, wdog_q} + WI'(1);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        m_ready_d     = '0;
        bus_data_d    = 1'b0;
        bus_valid_d   = 1'b0;
        bus_last_d    = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        wdog_d        = wdog_q;

        case (state_q)
            ARB_IDLE: begin
                if (m_rx_ready && any_req) begin
                    grant_d   = winner;
                    m_ready_d = NUM_SLAVES'(1) << winner;
                    state_d   = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (sel_valid) begin
                    wdog_d  = '0;
                    state_d = ARB_XFER;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_XFER: begin
                // Leave XFER the cycle after the completion pulse is registered,
                // which spaces back-to-back grants 12 cycles apart.
                if (frame_done_q || timeout_err_q) begin
                    state_d = ARB_GAP;
                end else begin
                    wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);
                    if (sel_done) begin
                        bus_data_d   = sel_data;
                        bus_valid_d  = 1'b1;
                        bus_last_d   = 1'b1;
                        frame_done_d = 1'b1;
                        rr_ptr_d     = grant_q;
                    end else if (wdog_inc >= WI'(TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        rr_ptr_d      = grant_q;
                    end else begin
                        bus_data_d  = sel_data;
                        bus_valid_d = 1'b1;
                    end
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= GRANT_ID_W'(NUM_SLAVES - 1);
            grant_q       <= '0;
            m_ready_q     <= '0;
            bus_data_q    <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_last_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            m_ready_q     <= m_ready_d;
            bus_data_q    <= bus_data_d;
            bus_valid_q   <= bus_valid_d;
            bus_last_q    <= bus_last_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
        end
    end

    assign m_ready     = m_ready_q;
    assign bus_data    = bus_data_q;
    assign bus_valid   = bus_valid_q;
    assign bus_last    = bus_last_q;
    assign grant_id    = grant_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench: behavioural slaves, a cycle-stamped scoreboard of expected bus
// bits / completion pulses / grant order, a priority table and corner-case sequences.
module tb_serial_bus_arbiter;
    import serial_bus_pkg::*;

    localparam int N  = 3;
    localparam int TO = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         m_rx_ready = 1'b0;
    logic [N-1:0] s_valid = '0;
    logic [N-1:0] s_tx_done = '0;
    logic [N-1:0] tx_data = '0;
    logic [N-1:0] m_ready;
    logic         bus_data, bus_valid, bus_last, frame_done, timeout_err;
    logic [2:0]   grant_id;

    serial_bus_arbiter #(
        .NUM_SLAVES (N),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_rx_ready  (m_rx_ready),
        .s_valid     (s_valid),
        .s_tx_done   (s_tx_done),
        .tx_data     (tx_data),
        .m_ready     (m_ready),
        .bus_data    (bus_data),
        .bus_valid   (bus_valid),
        .bus_last    (bus_last),
        .grant_id    (grant_id),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int cyc; logic data; logic last; } bit_exp_t;
    typedef struct { int cyc; int id; } evt_exp_t;
    typedef struct { logic [N-1:0] req; logic [7:0] data; int exp_grant; } vec_t;

    bit_exp_t bit_q[$];
    evt_exp_t done_q[$];
    evt_exp_t tout_q[$];
    int       grant_q[$];
    int       grant_cyc[$];

    logic [7:0]   sl_byte [N];
    bit           sl_nodone [N];
    int           sl_pos [N];
    logic [N-1:0] req = '0;
    logic [N-1:0] prev_m_ready = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name, input int exp_cyc);
        checks++;
        errors++;
        $display("FAIL %s: event not seen, expected at cycle %0d (now %0d)", name, exp_cyc, cyc);
    endtask

    task automatic flush();
        bit_q.delete();
        done_q.delete();
        tout_q.delete();
        grant_q.delete();
        grant_cyc.delete();
        for (int i = 0; i < N; i++) sl_pos[i] = -1;
    endtask

    task automatic monitor();
        bit_exp_t b;
        evt_exp_t e;
        logic     exp_v;
        int       g;
        while (bit_q.size() != 0 && bit_q[0].cyc < cyc) begin b = bit_q.pop_front(); miss("bus_bit", b.cyc); end
        while (done_q.size() != 0 && done_q[0].cyc < cyc) begin e = done_q.pop_front(); miss("frame_done", e.cyc); end
        while (tout_q.size() != 0 && tout_q[0].cyc < cyc) begin e = tout_q.pop_front(); miss("timeout_err", e.cyc); end

        exp_v = (bit_q.size() != 0 && bit_q[0].cyc == cyc);
        check("bus_valid", bus_valid, exp_v);
        if (exp_v) begin
            b = bit_q.pop_front();
            check("bus_data", bus_data, b.data);
            check("bus_last", bus_last, b.last);
        end else begin
            check("bus_last_idle", bus_last, 0);
        end

        exp_v = (done_q.size() != 0 && done_q[0].cyc == cyc);
        check("frame_done", frame_done, exp_v);
        if (exp_v) begin
            e = done_q.pop_front();
            check("done_grant_id", grant_id, e.id);
            $display("frame done: slave %0d at cycle %0d", e.id, cyc);
        end

        exp_v = (tout_q.size() != 0 && tout_q[0].cyc == cyc);
        check("timeout_err", timeout_err, exp_v);
        if (exp_v) begin
            e = tout_q.pop_front();
            $display("watchdog expiry: slave %0d at cycle %0d", e.id, cyc);
        end

        if (m_ready != '0) begin
            check("m_ready_onehot", $onehot(m_ready), 1);
            check("m_ready_single_cycle", prev_m_ready, 0);
            grant_cyc.push_back(cyc);
            if (grant_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got m_ready=%b, expected none (cycle %0d)", m_ready, cyc);
            end else begin
                g = grant_q.pop_front();
                check("grant_id", grant_id, g);
                check("m_ready", m_ready, 1 << g);
                $display("grant: slave %0d at cycle %0d", g, cyc);
            end
            for (int i = 0; i < N; i++) begin
                if (m_ready[i] && s_valid[i]) begin
                    sl_pos[i] = 0;
                    req[i]    = 1'b0;
                    if (!sl_nodone[i]) begin
                        for (int k = 0; k < FRAME_BITS; k++)
                            bit_q.push_back('{cyc + 2 + k, sl_byte[i][k], (k == FRAME_BITS - 1)});
                        done_q.push_back('{cyc + 9, i});
                    end else begin
                        for (int k = 0; k < TO - 1; k++)
                            bit_q.push_back('{cyc + 2 + k, (k < 8) ? sl_byte[i][k] : 1'b0, 1'b0});
                        tout_q.push_back('{cyc + TO + 1, i});
                    end
                end
            end
        end
        prev_m_ready = m_ready;
    endtask

    // One clock: drive this cycle's slave inputs, then sample outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        tx_data   = '0;
        s_tx_done = '0;
        for (int i = 0; i < N; i++) begin
            if (sl_pos[i] >= 0) begin
                if (sl_pos[i] < 8) tx_data[i] = sl_byte[i][sl_pos[i]];
                if (sl_pos[i] == 7 && !sl_nodone[i]) s_tx_done[i] = 1'b1;
                sl_pos[i]++;
                if ((!sl_nodone[i] && sl_pos[i] == 8) || sl_pos[i] >= TO + 4) sl_pos[i] = -1;
            end
        end
        s_valid = req;
        monitor();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((bit_q.size() + done_q.size() + tout_q.size() + grant_q.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if ((bit_q.size() + done_q.size() + tout_q.size() + grant_q.size()) != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations after %0d cycles, expected 0",
                     bit_q.size() + done_q.size() + tout_q.size() + grant_q.size(), budget);
            flush();
        end
        repeat (3) tick();
    endtask

    task automatic wait_grants(input int count, input int budget);
        int n = 0;
        while (grant_cyc.size() < count && n < budget) begin
            tick();
            n++;
        end
        check("grant_arrived", grant_cyc.size() >= count, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_ready"}, m_ready, 0);
        check({tag, "_bus_data"}, bus_data, 0);
        check({tag, "_bus_valid"}, bus_valid, 0);
        check({tag, "_bus_last"}, bus_last, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < N; i++) sl_nodone[i] = 1'b0;
        flush();
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
    endtask

    vec_t vecs[6];
    int   t0;

    initial begin
        vecs[0] = '{3'b010, 8'hA5, 1};
        vecs[1] = '{3'b111, 8'h3C, 0};
        vecs[2] = '{3'b110, 8'hFF, 1};
        vecs[3] = '{3'b100, 8'h01, 2};
        vecs[4] = '{3'b101, 8'h80, 0};
        vecs[5] = '{3'b001, 8'h5A, 0};
        for (int i = 0; i < N; i++) begin
            sl_byte[i]   = 8'h00;
            sl_nodone[i] = 1'b0;
            sl_pos[i]    = -1;
        end

        // Priority from reset state and single-frame data path.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < N; i++) sl_byte[i] = vecs[v].data ^ 8'(i);
            m_rx_ready = 1'b1;
            grant_q.push_back(vecs[v].exp_grant);
            req = vecs[v].req;
            wait_grants(1, 20);
            req = '0;
            drain(40);
        end

        // All three requesting continuously: order 0,1,2,0 at 12-cycle spacing.
        do_reset();
        sl_byte[0] = 8'h11; sl_byte[1] = 8'hC3; sl_byte[2] = 8'h7E;
        m_rx_ready = 1'b1;
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2); grant_q.push_back(0);
        req = 3'b111;
        for (int k = 1; k <= 4; k++) begin
            wait_grants(k, 30);
            req = (k < 4) ? 3'b111 : 3'b000;
        end
        for (int k = 1; k < 4 && k < grant_cyc.size(); k++)
            check("grant_spacing", grant_cyc[k] - grant_cyc[k-1], 12);
        drain(40);

        // Reset in the middle of slave 1's frame (rr_ptr is 0 beforehand).
        grant_q.push_back(1);
        req = 3'b010;
        wait_grants(1, 20);
        t0 = cyc;
        req = '0;
        while (cyc < t0 + 5) tick();
        reset = 1'b1;
        flush();
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        tick();
        grant_q.push_back(0); grant_q.push_back(1);
        req = 3'b011;
        drain(80);

        // m_rx_ready low holds off all grants.
        do_reset();
        m_rx_ready = 1'b0;
        req = 3'b111;
        repeat (20) tick();
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
        m_rx_ready = 1'b1;
        wait_grants(1, 10);
        check("rx_ready_first_grant_delay", grant_cyc[0] - cyc, 0);
        drain(80);

        // Withdrawn request during GRANT keeps rr_ptr (1 after slave 1's frame).
        do_reset();
        m_rx_ready = 1'b1;
        grant_q.push_back(1);
        req = 3'b010;
        drain(40);
        grant_q.push_back(2);
        req = 3'b100;
        tick();
        req = 3'b000;
        tick();
        check("withdraw_grant_seen", grant_cyc.size(), 2);
        repeat (12) tick();
        grant_q.push_back(2); grant_q.push_back(0);
        req = 3'b101;
        drain(60);

        // Watchdog: slave 0 never finishes, slave 1 is served next.
        do_reset();
        sl_byte[0]   = 8'h96;
        sl_nodone[0] = 1'b1;
        m_rx_ready   = 1'b1;
        grant_q.push_back(0); grant_q.push_back(1);
        req = 3'b011;
        drain(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Round-robin arbiter that shares one serial-bus master receive path between `NUM_SLAVES` slave output ports. It picks one requesting slave, issues a single-cycle `m_ready` grant to complete that slave's `s_valid`/`m_ready` handshake, and then steers that slave's 8-bit LSB-first serial frame onto one registered bus output. It sits between the slave output ports and the master receive logic, and adds a watchdog for frames that never complete.

## Interface
- `NUM_SLAVES`, default 3: number of slave ports, 2..8.
- `TIMEOUT`, default 12: cycles after the handshake within which `s_tx_done` must arrive; must be ≥ 8.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `m_rx_ready`  in  1  master receive logic can accept a new frame.
- `s_valid`  in  `NUM_SLAVES`  per-slave request.
- `s_tx_done`  in  `NUM_SLAVES`  per-slave frame-complete flag; high in the same cycle as bit 7.
- `tx_data`  in  `NUM_SLAVES`  per-slave serial bit.
- `m_ready`  out  `NUM_SLAVES`  one-hot grant/handshake, registered.
- `bus_data`  out  1  steered serial bit, registered.
- `bus_valid`  out  1  `bus_data` carries a frame bit.
- `bus_last`  out  1  marks bit 7 of the frame.
- `grant_id`  out  3  index of the current or last granted slave.
- `frame_done`  out  1  one-cycle pulse when a frame completes cleanly.
- `timeout_err`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- Slave frame protocol:
  - Handshake happens in cycle T when `s_valid[i] && m_ready[i]`.
  - `tx_data[i]` carries bits 0..7 on cycles T+1..T+8.
  - `s_tx_done[i]` is high at T+8.
- The FSM has four states:
  - **IDLE**: all `m_ready` = 0. If `m_rx_ready` and any `s_valid` bit is set, choose the winner by round-robin, starting at `rr_ptr+1` and wrapping modulo `NUM_SLAVES`. Load `grant_id` and go to GRANT.
  - **GRANT**: lasts exactly one cycle with `m_ready[grant_id]` = 1.
    - If `s_valid[grant_id]` is high, the handshake occurs; clear the watchdog and go to XFER.
    - If it is low, the request was withdrawn: go to IDLE and leave `rr_ptr` unchanged.
  - **XFER**: `bus_data` <= `tx_data[grant_id]`, `bus_valid` <= 1, `bus_last` <= `s_tx_done[grant_id]`. The watchdog increments each cycle.
    - If `s_tx_done[grant_id]` is set: pulse `frame_done` next cycle, set `rr_ptr` <= `grant_id`, go to GAP.
    - If the watchdog reaches `TIMEOUT` first: pulse `timeout_err`, set `rr_ptr` <= `grant_id`, force `bus_valid` to 0, go to GAP.
  - **GAP**: one turnaround cycle with `bus_valid` = 0, then IDLE.
- Only the granted slave's inputs are observed. `s_valid`, `s_tx_done` and `tx_data` from other slaves are ignored while busy.
- `m_rx_ready` is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- Reset values: state = IDLE, `rr_ptr` = `NUM_SLAVES-1` (so slave 0 has first priority), and `m_ready`, `bus_data`, `bus_valid`, `bus_last`, `grant_id`, `frame_done`, `timeout_err`, watchdog all = 0.
- Reset mid-frame aborts immediately. No `frame_done` or `timeout_err` pulse is produced.
- The watchdog is 4 bits wide and saturates; it never wraps.

## Timing
- Request seen in IDLE at cycle R: `m_ready` is high at R+1 (= T).
- Bus output at T+2..T+9: `bus_valid` = 1, `bus_data` = bits 0..7. This is one cycle of register latency behind `tx_data`.
- `bus_last` = 1 and `frame_done` = 1 at T+9.
- GAP at T+10, IDLE at T+11. The earliest next grant is at T+12, giving 12 cycles per frame back-to-back.
- `m_ready` is never high for more than one consecutive cycle, and never high outside GRANT.
- `timeout_err` is asserted at handshake + `TIMEOUT` + 1.
- `frame_done` and `timeout_err` are mutually exclusive.

## Structure
- Shared package `serial_bus_pkg` holds:
  - `arb_state_t` enum {ARB_IDLE, ARB_GRANT, ARB_XFER, ARB_GAP}
  - `FRAME_BITS` = 8
  - `GRANT_ID_W` = 3
- Sub-module `rr_priority_picker`: combinational. It takes the request vector and `rr_ptr`, and returns a `winner` index plus an `any_req` flag.
- The top level holds the FSM, watchdog, grant register and output mux.

## Test plan
- Single request: `s_valid[1]` = 1, slave sends 0xA5, `m_rx_ready` = 1. Expect `m_ready[1]` high for one cycle, then `bus_data` = 1,0,1,0,0,1,0,1 on T+2..T+9, with `bus_last` and `frame_done` at T+9.
- All three slaves request continuously after reset. Expect grants in order 0,1,2,0, with frames spaced 12 cycles apart.
- `m_rx_ready` = 0 with `s_valid` = 3'b111. Expect no `m_ready` and no `bus_valid`; when `m_rx_ready` rises, slave 0 is granted first.
- `s_valid[2]` drops during its GRANT cycle. Expect return to IDLE with no `bus_valid`; slave 2 wins again when it re-requests.
- Granted slave never asserts `s_tx_done`. Expect `timeout_err` pulse at T+13 (`TIMEOUT` = 12), then the next requester is granted.
- Reset at T+5 of a frame. Expect all outputs 0 the next cycle, no `frame_done`, and slave 0 given priority afterwards.
